// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data wins ties; a starvation counter forces fetch through eventually.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [2:0]    LAT_INIT = 3'(READ_LAT - 1);
    localparam logic [SW-1:0] S_MAX    = SW'(STARVE_MAX);

    typedef enum logic { S_IDLE, S_WAIT } state_t;
    typedef enum logic { OWN_IF, OWN_D } owner_t;

    state_t        r_state;
    owner_t        r_owner;
    logic [2:0]    r_lat_cnt;
    logic [SW-1:0] r_starve_cnt;

    state_t        w_state_nxt;
    owner_t        w_owner_nxt;
    logic [2:0]    w_lat_nxt;
    logic [SW-1:0] w_starve_nxt;
    logic          w_ret;
    logic          w_opp;
    logic          w_d_win;
    logic          w_gnt_d;
    logic          w_gnt_if;

    // State, latency, owner and starvation registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IF;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_lat_cnt    <= w_lat_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Grant selection, read tracking and starvation bookkeeping
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_lat_nxt    = r_lat_cnt;
        w_starve_nxt = r_starve_cnt;

        // A return cycle doubles as a grant opportunity
        w_ret    = (r_state == S_WAIT) && (r_lat_cnt == 3'd0);
        w_opp    = rst_n && ((r_state == S_IDLE) || w_ret);
        w_d_win  = d_req && !(if_req && (r_starve_cnt == S_MAX));
        w_gnt_d  = w_opp && w_d_win;
        w_gnt_if = w_opp && if_req && !w_d_win;

        if ((r_state == S_WAIT) && (r_lat_cnt != 3'd0)) begin
            w_lat_nxt = r_lat_cnt - 3'd1;
        end
        if (w_ret) begin
            w_state_nxt = S_IDLE;
        end
        // Writes finish in the grant cycle; only reads open a wait window
        if (w_gnt_if || (w_gnt_d && !d_we)) begin
            w_state_nxt = S_WAIT;
            w_lat_nxt   = LAT_INIT;
            w_owner_nxt = w_gnt_d ? OWN_D : OWN_IF;
        end

        if (!if_req || w_gnt_if) begin
            w_starve_nxt = '0;
        end else if (w_gnt_d && (r_starve_cnt != S_MAX)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    assign if_gnt    = w_gnt_if;
    assign d_gnt     = w_gnt_d;
    assign mem_en    = w_gnt_if || w_gnt_d;
    assign mem_we    = w_gnt_d && d_we;
    assign mem_addr  = w_gnt_d ? d_addr : (w_gnt_if ? if_addr : '0);
    assign mem_wdata = w_gnt_d ? d_wdata : '0;
    assign mem_wmask = w_gnt_d ? d_wmask : '0;

    assign if_rvalid = w_ret && (r_owner == OWN_IF);
    assign d_rvalid  = w_ret && (r_owner == OWN_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = (r_state == S_WAIT);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the fetch path (IF) and the load/store path (D).
- Sits between the multi-cycle core control/datapath and the memory macro, and replaces direct drive of the memory enable and address mux.
- Issues one memory command per grant. Tracks the single outstanding read with a latency counter and routes read data back to its owner.
- Data has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, memory address width (byte address, passed through unchanged)
- DATA_W, 32, data width; DATA_W/8 write-mask bits
- READ_LAT, 2, cycles from read grant to valid mem_rdata; legal range 1..7
- STARVE_MAX, 4, consecutive fetch denials tolerated before fetch is forced to win; legal range ≥1

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch command issued this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_wmask until d_gnt
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wmask  in  DATA_W/8  byte write enables
- d_gnt  out  1  data command issued this cycle
- d_rvalid  out  1  one-cycle pulse, d_rdata valid (reads only)
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after the read command
- busy  out  1  read outstanding (state WAIT)

Behaviour:
- Reset, sampled at the clk edge with rst_n=0:
  - state=IDLE, starve_cnt=0, lat_cnt=0, owner=IF.
  - All gnt, rvalid and mem_* outputs are 0 in the cycle after.
- States:
  - IDLE: no read outstanding.
  - WAIT: read outstanding; lat_cnt counts down from READ_LAT-1.
- Grant opportunity: IDLE, or WAIT in the cycle lat_cnt==0 (the return cycle). Returns and new grants overlap, so with READ_LAT=1 reads are fully pipelined.
- Grant selection in an opportunity cycle, combinational from the current req inputs:
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both: grant IF if starve_cnt==STARVE_MAX, else grant D.
- Grant outputs:
  - Exactly one of if_gnt/d_gnt is asserted per grant.
  - mem_en=1 in the same cycle, with mem_* driven from the granted requester (IF: mem_we=0, wmask=0, wdata=0).
  - When no grant, mem_en=0 and mem_we=0.
- Writes (D, d_we=1):
  - Complete in the grant cycle; no rvalid.
  - State does not enter WAIT; the next grant is possible the following cycle.
- Reads:
  - On grant: state→WAIT, owner←granted requester, lat_cnt←READ_LAT-1.
  - In WAIT, lat_cnt decrements each cycle while >0.
  - When lat_cnt==0: assert owner's rvalid for exactly one cycle; rdata=mem_rdata. Then go to WAIT (new read granted same cycle) or IDLE.
- if_rdata and d_rdata:
  - Both are driven with mem_rdata at all times.
  - Only the matching rvalid qualifies them.
- starve_cnt, updated each clock:
  - Set to 0 if if_req=0 or if_gnt=1.
  - Incremented (saturating at STARVE_MAX) if if_req=1, d_gnt=1 and if_gnt=0.
  - Held otherwise, including cycles in WAIT with no opportunity.
- Requesters must not drop req before gnt. Behaviour if they do: the request is simply not granted; no error.
- Reset mid-read: outstanding read is discarded; no rvalid is ever issued for it.
- busy = (state==WAIT).

Test Plan:
- READ_LAT=2, if_req=1 if_addr=0x100 alone, mem returns 0xDEADBEEF: if_gnt at T with mem_en=1 mem_we=0 mem_addr=0x100; if_rvalid only at T+2 with if_rdata=0xDEADBEEF; no grant at T+1.
- d_req write d_addr=0x40 d_wdata=0x12345678 d_wmask=4'b0011: d_gnt at T with mem_we=1 mem_wmask=0011; no d_rvalid; a second write is granted at T+1.
- if_req and d_req (read) both high in IDLE, starve_cnt=0: d_gnt first; IF is granted at the next opportunity once d_req drops.
- STARVE_MAX=4, READ_LAT=1, if_req held high, d_req continuous writes: d_gnt for 4 cycles, if_gnt on the 5th; starve_cnt returns to 0; D is granted the next cycle.
- READ_LAT=1, back-to-back IF reads at 0x0, 0x4, 0x8: one grant per cycle; if_rvalid on three consecutive cycles, each one cycle after its grant.
- READ_LAT=3, D read granted at T, rst_n=0 at T+1: no d_rvalid at T+3; after release busy=0 and the first new request is granted immediately.
